// File: rtl/alu_operand_collector.sv
// alu_operand_collector
// Gathers operand A and operand B for one ALU operation, either from a single
// beat (IN_SEL=11) or from two separate beats. The result is presented as a
// registered ALU input bus. If the second operand does not arrive within
// TIMEOUT cycles, the operation is issued as a partial one and TIMEOUT_ERR
// pulses.
//
// Handshakes:
//   upstream - a beat transfers at a rising edge where IN_VALID=1 and
//              IN_READY=1. IN_READY is low in ISSUE and while RST is high.
//   ALU side - the presented operation (CE=1) transfers at a rising edge
//              where OUT_READY=1. All presented fields hold until then.
//
// Optional feature: define ALU_COLLECT_STATS_EN to build the saturating
// ISSUE_CNT / TIMEOUT_CNT statistics counters. Without it, both are tied to 0.
// The FSM state is visible on DBG_STATE (0 IDLE, 1 WAIT_A, 2 WAIT_B, 3 ISSUE).
module alu_operand_collector #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [1:0]    IN_SEL,
    input  logic [DW-1:0] IN_OPA,
    input  logic [DW-1:0] IN_OPB,
    input  logic [CW-1:0] IN_CMD,
    input  logic          IN_MODE,
    input  logic          IN_CIN,
    input  logic          OUT_READY,
    output logic [DW-1:0] OPA,
    output logic [DW-1:0] OPB,
    output logic [CW-1:0] CMD,
    output logic          MODE,
    output logic          CIN,
    output logic          CE,
    output logic [1:0]    INP_VALID,
    output logic          TIMEOUT_ERR,
    output logic [15:0]   ISSUE_CNT,
    output logic [15:0]   TIMEOUT_CNT,
    output logic [1:0]    DBG_STATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    // The wait timer reaches this value in the last cycle of the window.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic          mode_q, mode_d;
    logic          cin_q, cin_d;
    logic          ce_q, ce_d;
    logic [1:0]    inp_valid_q, inp_valid_d;
    logic          terr_q, terr_d;
    logic          accept;
    logic          partial_issue;

    assign IN_READY = (state_q != ISSUE) && !RST;
    assign accept   = IN_VALID && IN_READY;

    // Next-state, operand capture and timeout decision.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cmd_d         = cmd_q;
        mode_d        = mode_q;
        cin_d         = cin_q;
        inp_valid_d   = inp_valid_q;
        partial_issue = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (IN_SEL)
                        2'b11: begin
                            opa_d       = IN_OPA;
                            opb_d       = IN_OPB;
                            cmd_d       = IN_CMD;
                            mode_d      = IN_MODE;
                            cin_d       = IN_CIN;
                            inp_valid_d = 2'b11;
                            state_d     = ISSUE;
                        end
                        2'b01: begin
                            opa_d   = IN_OPA;
                            cmd_d   = IN_CMD;
                            mode_d  = IN_MODE;
                            cin_d   = IN_CIN;
                            timer_d = 8'd0;
                            state_d = WAIT_B;
                        end
                        2'b10: begin
                            opb_d   = IN_OPB;
                            cmd_d   = IN_CMD;
                            mode_d  = IN_MODE;
                            cin_d   = IN_CIN;
                            timer_d = 8'd0;
                            state_d = WAIT_A;
                        end
                        default: begin
                            // Empty beat: consumed and dropped.
                        end
                    endcase
                end
            end

            WAIT_B: begin
                // A completing beat wins over a timeout at the same edge.
                if (accept && IN_SEL[1]) begin
                    opb_d       = IN_OPB;
                    inp_valid_d = 2'b11;
                    state_d     = ISSUE;
                end else if (accept && IN_SEL == 2'b01) begin
                    opa_d   = IN_OPA;
                    cmd_d   = IN_CMD;
                    mode_d  = IN_MODE;
                    cin_d   = IN_CIN;
                    timer_d = 8'd0;
                end else if (timer_q == TIMER_LAST) begin
                    opb_d         = '0;
                    inp_valid_d   = 2'b01;
                    partial_issue = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            WAIT_A: begin
                if (accept && IN_SEL[0]) begin
                    opa_d       = IN_OPA;
                    inp_valid_d = 2'b11;
                    state_d     = ISSUE;
                end else if (accept && IN_SEL == 2'b10) begin
                    opb_d   = IN_OPB;
                    cmd_d   = IN_CMD;
                    mode_d  = IN_MODE;
                    cin_d   = IN_CIN;
                    timer_d = 8'd0;
                end else if (timer_q == TIMER_LAST) begin
                    opa_d         = '0;
                    inp_valid_d   = 2'b10;
                    partial_issue = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            ISSUE: begin
                if (OUT_READY) begin
                    inp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        ce_d   = (state_d == ISSUE);
        terr_d = partial_issue;
    end

    // State and registered ALU bus; reset discards any held operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            timer_q     <= 8'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            ce_q        <= ce_d;
            inp_valid_q <= inp_valid_d;
            terr_q      <= terr_d;
        end
    end

`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    // Saturating counters: completed issues and partial issues.
    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (state_q == ISSUE && OUT_READY && issue_cnt_q != 16'hFFFF)
            issue_cnt_d = issue_cnt_q + 16'd1;
        if (partial_issue && timeout_cnt_q != 16'hFFFF)
            timeout_cnt_d = timeout_cnt_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_cnt_q   <= 16'd0;
            timeout_cnt_q <= 16'd0;
        end else begin
            issue_cnt_q   <= issue_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign ISSUE_CNT   = issue_cnt_q;
    assign TIMEOUT_CNT = timeout_cnt_q;
`else
    assign ISSUE_CNT   = 16'd0;
    assign TIMEOUT_CNT = 16'd0;
`endif

    assign OPA         = opa_q;
    assign OPB         = opb_q;
    assign CMD         = cmd_q;
    assign MODE        = mode_q;
    assign CIN         = cin_q;
    assign CE          = ce_q;
    assign INP_VALID   = inp_valid_q;
    assign TIMEOUT_ERR = terr_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed testbench for alu_operand_collector (DW=8, CW=4, TIMEOUT=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_operand_collector;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [1:0] IN_SEL;
    logic [7:0] IN_OPA;
    logic [7:0] IN_OPB;
    logic [3:0] IN_CMD;
    logic       IN_MODE;
    logic       IN_CIN;
    logic       OUT_READY;
    logic [7:0] OPA;
    logic [7:0] OPB;
    logic [3:0] CMD;
    logic       MODE;
    logic       CIN;
    logic       CE;
    logic [1:0] INP_VALID;
    logic       TIMEOUT_ERR;
    logic [15:0] ISSUE_CNT;
    logic [15:0] TIMEOUT_CNT;
    logic [1:0] DBG_STATE;

`ifdef ALU_COLLECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_cmp;
    int n_bad;
    logic [15:0] exp_issue;
    logic [15:0] exp_to;

    alu_operand_collector #(.DW(8), .CW(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_SEL(IN_SEL), .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CMD(IN_CMD),
        .IN_MODE(IN_MODE), .IN_CIN(IN_CIN), .OUT_READY(OUT_READY),
        .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
        .INP_VALID(INP_VALID), .TIMEOUT_ERR(TIMEOUT_ERR),
        .ISSUE_CNT(ISSUE_CNT), .TIMEOUT_CNT(TIMEOUT_CNT), .DBG_STATE(DBG_STATE)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One accepted beat, then the bus goes idle.
    task automatic beat(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cmd, input logic mode, input logic cin);
        IN_VALID = 1'b1;
        IN_SEL   = sel;
        IN_OPA   = a;
        IN_OPB   = b;
        IN_CMD   = cmd;
        IN_MODE  = mode;
        IN_CIN   = cin;
        step();
        IN_VALID = 1'b0;
        IN_SEL   = 2'b00;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=0", IN_READY); end
        n_cmp++; if (CE !== 1'b0) begin n_bad++; $display("FAIL rst_ce got=%b exp=0", CE); end
        n_cmp++; if (INP_VALID !== 2'b00) begin n_bad++; $display("FAIL rst_inp_valid got=%b exp=00", INP_VALID); end
        n_cmp++; if ({OPA, OPB, CMD, MODE, CIN, TIMEOUT_ERR} !== 23'd0) begin n_bad++;
            $display("FAIL rst_fields got opa=%h opb=%h cmd=%h mode=%b cin=%b terr=%b exp all 0", OPA, OPB, CMD, MODE, CIN, TIMEOUT_ERR); end
        n_cmp++; if ({ISSUE_CNT, TIMEOUT_CNT} !== 32'd0) begin n_bad++;
            $display("FAIL rst_counters got=%h/%h exp=0/0", ISSUE_CNT, TIMEOUT_CNT); end
        RST = 1'b0;
        step();
        n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_full_issue();
        OUT_READY = 1'b1;
        beat(2'b11, 8'h3C, 8'h05, 4'h0, 1'b0, 1'b0);
        n_cmp++; if (CE !== 1'b1 || INP_VALID !== 2'b11) begin n_bad++;
            $display("FAIL full_ce got ce=%b iv=%b exp ce=1 iv=11", CE, INP_VALID); end
        n_cmp++; if (OPA !== 8'h3C || OPB !== 8'h05 || CMD !== 4'h0) begin n_bad++;
            $display("FAIL full_data got opa=%h opb=%h cmd=%h exp 3c 05 0", OPA, OPB, CMD); end
        n_cmp++; if (IN_READY !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin n_bad++;
            $display("FAIL full_ready got rdy=%b terr=%b exp 0 0", IN_READY, TIMEOUT_ERR); end
        step();
        exp_issue++;
        n_cmp++; if (CE !== 1'b0 || INP_VALID !== 2'b00 || IN_READY !== 1'b1) begin n_bad++;
            $display("FAIL full_release got ce=%b iv=%b rdy=%b exp 0 00 1", CE, INP_VALID, IN_READY); end
        n_cmp++; if (OPA !== 8'h3C || OPB !== 8'h05) begin n_bad++;
            $display("FAIL full_retain got opa=%h opb=%h exp 3c 05", OPA, OPB); end
    endtask

    task automatic test_two_beat();
        OUT_READY = 1'b1;
        beat(2'b01, 8'hAA, 8'h77, 4'h5, 1'b1, 1'b1);
        n_cmp++; if (CE !== 1'b0 || OPA !== 8'hAA || INP_VALID !== 2'b00) begin n_bad++;
            $display("FAIL two_first got ce=%b opa=%h iv=%b exp 0 aa 00", CE, OPA, INP_VALID); end
        step();
        step();
        beat(2'b10, 8'h99, 8'h55, 4'hA, 1'b0, 1'b0);
        n_cmp++; if (CE !== 1'b1 || INP_VALID !== 2'b11 || TIMEOUT_ERR !== 1'b0) begin n_bad++;
            $display("FAIL two_issue got ce=%b iv=%b terr=%b exp 1 11 0", CE, INP_VALID, TIMEOUT_ERR); end
        n_cmp++; if (OPA !== 8'hAA || OPB !== 8'h55 || CMD !== 4'h5 || MODE !== 1'b1 || CIN !== 1'b1) begin n_bad++;
            $display("FAIL two_data got opa=%h opb=%h cmd=%h mode=%b cin=%b exp aa 55 5 1 1", OPA, OPB, CMD, MODE, CIN); end
        step();
        exp_issue++;
        n_cmp++; if (CE !== 1'b0) begin n_bad++; $display("FAIL two_release got ce=%b exp=0", CE); end
    endtask

    task automatic test_timeout();
        int cnt;
        OUT_READY = 1'b0;
        beat(2'b01, 8'h11, 8'hEE, 4'h3, 1'b0, 1'b1);
        cnt = 0;
        while (CE !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        exp_to++;
        n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL to_latency got=%0d exp=16", cnt); end
        n_cmp++; if (INP_VALID !== 2'b01 || OPA !== 8'h11 || OPB !== 8'h00) begin n_bad++;
            $display("FAIL to_data got iv=%b opa=%h opb=%h exp 01 11 00", INP_VALID, OPA, OPB); end
        n_cmp++; if (TIMEOUT_ERR !== 1'b1) begin n_bad++; $display("FAIL to_err_high got=%b exp=1", TIMEOUT_ERR); end
        step();
        n_cmp++; if (TIMEOUT_ERR !== 1'b0 || CE !== 1'b1) begin n_bad++;
            $display("FAIL to_err_pulse got terr=%b ce=%b exp 0 1", TIMEOUT_ERR, CE); end
        OUT_READY = 1'b1;
        step();
        exp_issue++;
        n_cmp++; if (CE !== 1'b0) begin n_bad++; $display("FAIL to_release got ce=%b exp=0", CE); end
        n_cmp++; if (TIMEOUT_CNT !== (STATS ? exp_to : 16'd0) || ISSUE_CNT !== (STATS ? exp_issue : 16'd0)) begin n_bad++;
            $display("FAIL to_counters got=%0d/%0d exp=%0d/%0d", ISSUE_CNT, TIMEOUT_CNT,
                     STATS ? exp_issue : 16'd0, STATS ? exp_to : 16'd0); end
    endtask

    task automatic test_late_complete();
        OUT_READY = 1'b1;
        beat(2'b01, 8'h24, 8'h00, 4'h7, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (CE !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin n_bad++;
            $display("FAIL late_wait got ce=%b terr=%b exp 0 0", CE, TIMEOUT_ERR); end
        beat(2'b10, 8'h00, 8'h42, 4'h1, 1'b1, 1'b1);
        n_cmp++; if (CE !== 1'b1 || INP_VALID !== 2'b11 || TIMEOUT_ERR !== 1'b0) begin n_bad++;
            $display("FAIL late_issue got ce=%b iv=%b terr=%b exp 1 11 0", CE, INP_VALID, TIMEOUT_ERR); end
        n_cmp++; if (OPA !== 8'h24 || OPB !== 8'h42 || CMD !== 4'h7) begin n_bad++;
            $display("FAIL late_data got opa=%h opb=%h cmd=%h exp 24 42 7", OPA, OPB, CMD); end
        step();
        exp_issue++;
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b0;
        beat(2'b11, 8'h81, 8'h7E, 4'h9, 1'b1, 1'b0);
        IN_VALID = 1'b1;
        IN_SEL   = 2'b11;
        IN_OPA   = 8'hFF;
        IN_OPB   = 8'hFF;
        IN_CMD   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (CE !== 1'b1 || IN_READY !== 1'b0 || INP_VALID !== 2'b11 || OPA !== 8'h81 ||
                         OPB !== 8'h7E || CMD !== 4'h9 || MODE !== 1'b1 || CIN !== 1'b0) begin n_bad++;
                $display("FAIL bp_hold cyc=%0d got ce=%b rdy=%b iv=%b opa=%h opb=%h cmd=%h exp 1 0 11 81 7e 9",
                         i, CE, IN_READY, INP_VALID, OPA, OPB, CMD); end
            step();
        end
        IN_VALID  = 1'b0;
        IN_SEL    = 2'b00;
        OUT_READY = 1'b1;
        step();
        exp_issue++;
        n_cmp++; if (CE !== 1'b0 || INP_VALID !== 2'b00 || OPA !== 8'h81) begin n_bad++;
            $display("FAIL bp_release got ce=%b iv=%b opa=%h exp 0 00 81", CE, INP_VALID, OPA); end
    endtask

    task automatic test_reset_in_wait();
        logic saw_ce;
        OUT_READY = 1'b1;
        beat(2'b01, 8'h5A, 8'h00, 4'h2, 1'b1, 1'b1);
        step();
        step();
        RST = 1'b1;
        step();
        exp_issue = 16'd0;
        exp_to    = 16'd0;
        n_cmp++; if ({OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, TIMEOUT_ERR} !== 26'd0 || IN_READY !== 1'b0) begin n_bad++;
            $display("FAIL rw_clear got opa=%h cmd=%h mode=%b cin=%b ce=%b iv=%b rdy=%b exp all 0",
                     OPA, CMD, MODE, CIN, CE, INP_VALID, IN_READY); end
        n_cmp++; if ({ISSUE_CNT, TIMEOUT_CNT} !== 32'd0) begin n_bad++;
            $display("FAIL rw_counters got=%h/%h exp=0/0", ISSUE_CNT, TIMEOUT_CNT); end
        RST = 1'b0;
        saw_ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (CE === 1'b1) saw_ce = 1'b1;
        end
        n_cmp++; if (saw_ce !== 1'b0) begin n_bad++; $display("FAIL rw_no_issue got ce_seen=%b exp=0", saw_ce); end
        beat(2'b11, 8'h12, 8'h34, 4'h6, 1'b0, 1'b1);
        n_cmp++; if (CE !== 1'b1 || INP_VALID !== 2'b11 || OPA !== 8'h12 || OPB !== 8'h34) begin n_bad++;
            $display("FAIL rw_after got ce=%b iv=%b opa=%h opb=%h exp 1 11 12 34", CE, INP_VALID, OPA, OPB); end
        step();
        exp_issue++;
    endtask

    task automatic test_restart();
        int cnt;
        OUT_READY = 1'b1;
        beat(2'b00, 8'hC3, 8'hC3, 4'hC, 1'b0, 1'b0);
        n_cmp++; if (CE !== 1'b0 || IN_READY !== 1'b1 || OPA !== 8'h12) begin n_bad++;
            $display("FAIL empty_beat got ce=%b rdy=%b opa=%h exp 0 1 12", CE, IN_READY, OPA); end
        beat(2'b10, 8'h00, 8'h10, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        beat(2'b10, 8'h00, 8'h20, 4'h2, 1'b1, 1'b0);
        // Empty beats during the wait are accepted but must not affect the timer.
        IN_VALID = 1'b1;
        IN_SEL   = 2'b00;
        cnt = 0;
        while (CE !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        IN_VALID = 1'b0;
        exp_to++;
        n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL restart_latency got=%0d exp=16", cnt); end
        n_cmp++; if (INP_VALID !== 2'b10 || OPA !== 8'h00 || OPB !== 8'h20 || CMD !== 4'h2 || TIMEOUT_ERR !== 1'b1) begin n_bad++;
            $display("FAIL restart_data got iv=%b opa=%h opb=%h cmd=%h terr=%b exp 10 00 20 2 1",
                     INP_VALID, OPA, OPB, CMD, TIMEOUT_ERR); end
        step();
        exp_issue++;
        n_cmp++; if (CE !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin n_bad++;
            $display("FAIL restart_release got ce=%b terr=%b exp 0 0", CE, TIMEOUT_ERR); end
        n_cmp++; if (ISSUE_CNT !== (STATS ? exp_issue : 16'd0) || TIMEOUT_CNT !== (STATS ? exp_to : 16'd0)) begin n_bad++;
            $display("FAIL final_counters got=%0d/%0d exp=%0d/%0d", ISSUE_CNT, TIMEOUT_CNT,
                     STATS ? exp_issue : 16'd0, STATS ? exp_to : 16'd0); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_issue = 16'd0;
        exp_to    = 16'd0;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        IN_SEL    = 2'b00;
        IN_OPA    = 8'h00;
        IN_OPB    = 8'h00;
        IN_CMD    = 4'h0;
        IN_MODE   = 1'b0;
        IN_CIN    = 1'b0;
        OUT_READY = 1'b0;
        test_reset();
        test_full_issue();
        test_two_beat();
        test_timeout();
        test_late_complete();
        test_backpressure();
        test_reset_in_wait();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 Parameter DW, default 8, operand width in bits.
REQ-002 Parameter CW, default 4, command width in bits.
REQ-003 Parameter TIMEOUT, default 16, wait window in cycles for the missing operand; legal range 2..255.
REQ-004 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 IN_VALID  input  1  upstream beat valid.
REQ-007 IN_READY  output  1  collector can accept a beat.
REQ-008 IN_SEL  input  2  operand presence: 01 OPA only, 10 OPB only, 11 both, 00 none.
REQ-009 IN_OPA / IN_OPB  input  DW each  operand data.
REQ-010 IN_CMD  input  CW, IN_MODE  input  1, IN_CIN  input  1  operation fields.
REQ-011 OUT_READY  input  1  ALU side accepts the presented operation.
REQ-012 OPA, OPB  output  DW; CMD  output  CW; MODE, CIN, CE  output  1; INP_VALID  output  2  registered ALU input bus.
REQ-013 TIMEOUT_ERR  output  1  single-cycle pulse when a partial operation is issued.
REQ-014 ISSUE_CNT, TIMEOUT_CNT  output  16 each  statistics (see Configuration).

Function
REQ-015 A beat SHALL be accepted at a rising edge where IN_VALID=1 and IN_READY=1.
REQ-016 FSM states SHALL be IDLE, WAIT_A, WAIT_B, ISSUE; IN_READY=1 in IDLE/WAIT_A/WAIT_B, 0 in ISSUE.
REQ-017 IDLE: SEL=11 latches all fields -> ISSUE; SEL=01 latches OPA, CMD, MODE, CIN -> WAIT_B; SEL=10 latches OPB, CMD, MODE, CIN -> WAIT_A; SEL=00 accepted and discarded, stay IDLE.
REQ-018 WAIT_B: beat with IN_SEL[1]=1 latches only OPB (CMD/MODE/CIN kept from first beat) -> ISSUE with INP_VALID=11; WAIT_A symmetric on IN_SEL[0].
REQ-019 WAIT_B: beat with SEL=01 replaces OPA, CMD, MODE, CIN and restarts timer; WAIT_A symmetric for SEL=10; SEL=00 ignored, timer continues.
REQ-020 Wait timer SHALL clear on entering/restarting a wait state and increment each wait cycle; at the edge where it equals TIMEOUT-1 with no completing beat, go to ISSUE with INP_VALID=01 (WAIT_B) or 10 (WAIT_A) and missing operand driven 0.
REQ-021 Completing beat and timeout at the same edge: completion SHALL win, INP_VALID=11, no TIMEOUT_ERR.
REQ-022 ISSUE: CE=1; OPA, OPB, CMD, MODE, CIN, INP_VALID SHALL hold stable until an edge with OUT_READY=1, then -> IDLE with CE=0 and INP_VALID=00 next cycle.
REQ-023 TIMEOUT_ERR SHALL pulse high for exactly the first ISSUE cycle of a partial operation.
REQ-024 Latency: SEL=11 beat accepted at edge N SHALL show CE=1 in the cycle after N; maximum throughput one operation per two cycles.
REQ-025 Outputs other than CE/INP_VALID SHALL retain last values in IDLE/WAIT.

Reset
REQ-026 RST=1 at an edge SHALL force IDLE, timer 0, and OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, TIMEOUT_ERR, ISSUE_CNT, TIMEOUT_CNT to 0.
REQ-027 Reset in WAIT or ISSUE SHALL discard the held operation; it is never issued.
REQ-028 IN_READY SHALL be 0 while RST=1.

Configuration
REQ-029 Macro ALU_COLLECT_STATS_EN defined: ISSUE_CNT increments per completed issue (ISSUE with OUT_READY=1), TIMEOUT_CNT per partial issue, both saturating at 16'hFFFF.
REQ-030 Macro undefined: counters not implemented; ISSUE_CNT and TIMEOUT_CNT tied to 0; all other behaviour identical.

Verification
REQ-031 SEL=11, OPA=8'h3C, OPB=8'h05, CMD=0, OUT_READY=1 -> next cycle CE=1, INP_VALID=11, OPA=3C, OPB=05; CE=0 the cycle after.
REQ-032 SEL=01 OPA=8'hAA, then SEL=10 OPB=8'h55 three cycles later -> one issue, INP_VALID=11, OPA=AA, OPB=55, CMD from first beat, TIMEOUT_ERR=0.
REQ-033 SEL=01 OPA=8'h11 alone, TIMEOUT=16 -> CE=1 with INP_VALID=01, OPB=0, TIMEOUT_ERR one-cycle pulse, 16 cycles after acceptance; TIMEOUT_CNT=1 with macro.
REQ-034 SEL=10 completing beat at timer=TIMEOUT-1 -> INP_VALID=11, no TIMEOUT_ERR.
REQ-035 Issue presented with OUT_READY=0 for 5 cycles -> outputs stable, IN_READY=0; released one cycle after OUT_READY=1.
REQ-036 RST=1 during WAIT_B after SEL=01 -> all outputs 0, no CE pulse, later SEL=11 beat issues normally.
